ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  clock; one clock, reset is asynchronous and active-high.
REQ-002 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have port: stall  in  `StallBus  pipeline stall vector; bit 2 = ID->EX hold, bit 3 = EX->MEM hold.
REQ-004 SHALL have port: id_to_ex_bus  in  `ID_TO_EX_WD (159)  {pc 158:127, inst 126:95, alu_op 94:83, sel_alu_src1 82:80, sel_alu_src2 79:76, data_ram_en 75, data_ram_wen 74:71, rf_we 70, rf_waddr 69:65, sel_rf_res 64, rdata1 63:32, rdata2 31:0}.
REQ-005 SHALL have port: ex_to_mem_bus  out  `EX_TO_MEM_WD (76)  {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}.
REQ-006 SHALL have port: ex_to_rf_bus  out  `EX_TO_RF_WD (38)  {rf_we, rf_waddr, ex_result} forwarding to ID.
REQ-007 SHALL have ports: data_sram_en out 1, data_sram_wen out 4, data_sram_addr out 32, data_sram_wdata out 32.
REQ-008 SHALL have port: stallreq_for_ex  out  1  requests pipeline hold while the multi-cycle unit is busy.

Function
REQ-009 Input register: stall[2]=Stop & stall[3]=NoStop -> load zeros (bubble); stall[2]=NoStop -> load id_to_ex_bus; else hold.
REQ-010 src1 one-hot: [0] rdata1, [1] pc, [2] zero-extended inst[10:6]; src2 one-hot: [0] rdata2, [1] sign-ext imm, [2] 32'd8, [3] zero-ext imm.
REQ-011 ALU one-hot alu_op order {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}; shifts use src1[4:0] as amount on src2; lui = imm<<16; all arithmetic mod 2^32, no overflow trap.
REQ-012 Decode from inst (opcode 0): MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
REQ-013 ex_result = HI for MFHI, LO for MFLO, else ALU result; rf_we/rf_waddr pass through, forced rf_we=1 with rf_waddr=inst[15:11] for MFHI/MFLO.
REQ-014 HI/LO 32-bit registers SHALL update only on an edge where stall[3]=NoStop; MTHI/MTLO write rdata1; MULT/MULTU write {HI,LO}=64-bit signed/unsigned product.
REQ-015 Divider FSM states IDLE, DIV_ON, DIV_END; IDLE->DIV_ON when DIV/DIVU present and done flag clear; DIV_ON runs 32 restoring iterations (counter 0..31) then ->DIV_END; DIV_END->IDLE after one cycle.
REQ-016 stallreq_for_ex SHALL be 1 in IDLE with an unstarted divide and throughout DIV_ON (33 cycles total), 0 in DIV_END; HI<=remainder, LO<=quotient at the DIV_END edge.
REQ-017 Signed divide on magnitudes; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-018 Divisor zero: no iteration, DIV_END next cycle (stall 1 cycle), LO=32'hFFFF_FFFF, HI=dividend.
REQ-019 Done flag set at DIV_END, cleared when the input register loads; prevents re-issue when downstream stall holds EX after completion.
REQ-020 data_sram_en=data_ram_en, wen=data_ram_wen, addr=ex_result, wdata=rdata2; all zero for a bubble.
REQ-021 A bubble in EX SHALL produce rf_we=0, data_sram_en=0, no HI/LO write.

Reset
REQ-022 rst SHALL asynchronously clear input register, HI, LO, FSM (IDLE), counter, done flag; all outputs therefore 0, stallreq_for_ex=0.
REQ-023 rst mid-divide SHALL abort without HI/LO update.

Configuration
REQ-024 Macro EX_MUL_ITER_EN defined: MULT/MULTU use the same FSM path as divide (32 shift-add iterations, stall 33 cycles, result at DIV_END); undefined: single-cycle product, no stall.

Structure
REQ-025 `StallBus, `Stop/`NoStop, `ID_TO_EX_WD, `EX_TO_MEM_WD, `EX_TO_RF_WD, funct codes in lib/defines.vh.
REQ-026 Iterative divider (and optional multiplier) SHALL be sub-module div with start/signed/opa/opb in, ready/result[63:0] out.

Verification
REQ-027 addu rdata1=5, rdata2=0xFFFFFFFF -> ex_result=4, ex_to_rf_bus={1,rd,4} same cycle.
REQ-028 DIV 7 / -2 -> stallreq 33 cycles, then LO=0xFFFFFFFD, HI=1; MFLO next -> 0xFFFFFFFD.
REQ-029 DIVU 10/0 -> stallreq 1 cycle, LO=0xFFFFFFFF, HI=10.
REQ-030 MULT 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; stall 0 cycles (33 with EX_MUL_ITER_EN).
REQ-031 sw base 0x100 imm 8, rdata2=0xDEADBEEF -> data_sram_en=1, wen=4'hF, addr=0x108, wdata=0xDEADBEEF.
REQ-032 rst asserted at DIV_ON counter 10 -> state IDLE, HI/LO=0, stallreq 0 immediately.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// EX stage shared types, bus widths and MIPS funct codes.
// EX_MUL_ITER_EN selects the iterative multiplier in ex_stage/ex_stage_div.
package ex_stage_pkg;

  localparam int STALL_W      = 6;
  localparam int STALL_ID_EX  = 2;
  localparam int STALL_EX_MEM = 3;
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  typedef enum logic [1:0] {
    IDLE,
    DIV_ON,
    DIV_END
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider; with EX_MUL_ITER_EN also a shift-add
// multiplier sharing the same IDLE/DIV_ON/DIV_END sequencer.
module ex_stage_div
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
`ifdef EX_MUL_ITER_EN
  input  logic        mul,
`endif
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        ready,
  output logic [63:0] result
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        mul_q, mul_d;
  logic        mul_in;
  logic        zero_div;
  logic [31:0] abs_a, abs_b;
  logic [33:0] sub;
  logic [32:0] madd;

`ifdef EX_MUL_ITER_EN
  assign mul_in = mul;
`else
  assign mul_in = 1'b0;
`endif

  assign zero_div = ~mul_in & (opb == 32'd0);

  // sequencer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // a zero divisor skips the iterations entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = zero_div ? DIV_END : DIV_ON;
      DIV_ON:  if (cnt_q == 5'd31) state_d = DIV_END;
      DIV_END: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      mul_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      mul_q  <= mul_d;
    end
  end

  // operand capture on start, one shift step per DIV_ON cycle
  always_comb begin
    abs_a  = (is_signed & opa[31]) ? -opa : opa;
    abs_b  = (is_signed & opb[31]) ? -opb : opb;
    sub    = {1'b0, acc_q[63:31]} - {2'b00, dvs_q};
    madd   = {1'b0, acc_q[63:32]}
           + {1'b0, (acc_q[0] ? dvs_q : 32'd0)};
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    dvs_d  = dvs_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    mul_d  = mul_q;
    if (state_q == IDLE && start) begin
      cnt_d = 5'd0;
      mul_d = mul_in;
      if (zero_div) begin
        acc_d  = {opa, 32'hFFFF_FFFF};
        dvs_d  = 32'd0;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else begin
        acc_d  = {32'd0, abs_a};
        dvs_d  = abs_b;
        qneg_d = is_signed & (opa[31] ^ opb[31]);
        rneg_d = is_signed & opa[31] & ~mul_in;
      end
    end else if (state_q == DIV_ON) begin
      cnt_d = cnt_q + 5'd1;
      if (mul_q)
        acc_d = {madd, acc_q[31:1]};
      else if (!sub[33])
        acc_d = {sub[31:0], acc_q[30:0], 1'b1};
      else
        acc_d = {acc_q[62:0], 1'b0};
    end
  end

  // sign-corrected result, held stable until the next start
  always_comb begin
    ready = (state_q == DIV_END);
    if (mul_q) begin
      result = qneg_q ? -acc_q : acc_q;
    end else begin
      result[31:0]  = qneg_q ? -acc_q[31:0] : acc_q[31:0];
      result[63:32] = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    end
  end

endmodule

// File: rtl/ex_stage.sv
// EX pipeline stage: input register, ALU, HI/LO, multi-cycle div/mul.
// EX_MUL_ITER_EN routes MULT/MULTU through the iterative unit.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_ex_t      id_q, id_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        in_load;

  logic        op_r;
  logic [5:0]  funct;
  logic        is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic        is_mult, is_multu, is_div, is_divu;
  logic        iter_op, div_signed, div_start;
  logic        div_ready;
  logic [63:0] div_result;

  logic [31:0] imm_s, imm_z;
  logic [31:0] src1, src2, alu_res;
  logic [31:0] ex_result;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  ex_mem_t     mem_out;
  logic        unused_bits;

  // pipeline register: bubble, load or hold
  always_comb begin
    id_d    = id_q;
    in_load = 1'b0;
    if (stall[STALL_ID_EX] == STOP
        && stall[STALL_EX_MEM] == NO_STOP) begin
      id_d    = '0;
      in_load = 1'b1;
    end else if (stall[STALL_ID_EX] == NO_STOP) begin
      id_d    = id_ex_t'(id_to_ex_bus);
      in_load = 1'b1;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      id_q   <= id_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  // special-opcode decode
  always_comb begin
    op_r     = (id_q.inst[31:26] == 6'd0);
    funct    = id_q.inst[5:0];
    is_mfhi  = op_r & (funct == F_MFHI);
    is_mflo  = op_r & (funct == F_MFLO);
    is_mthi  = op_r & (funct == F_MTHI);
    is_mtlo  = op_r & (funct == F_MTLO);
    is_mult  = op_r & (funct == F_MULT);
    is_multu = op_r & (funct == F_MULTU);
    is_div   = op_r & (funct == F_DIV);
    is_divu  = op_r & (funct == F_DIVU);
  end

`ifdef EX_MUL_ITER_EN
  assign iter_op = is_div | is_divu | is_mult | is_multu;
`else
  assign iter_op = is_div | is_divu;
`endif

  assign div_signed = is_div | is_mult;
  assign div_start  = iter_op & ~done_q;

  ex_stage_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (div_signed),
`ifdef EX_MUL_ITER_EN
    .mul       (is_mult | is_multu),
`endif
    .opa       (id_q.rdata1),
    .opb       (id_q.rdata2),
    .ready     (div_ready),
    .result    (div_result)
  );

  assign stallreq_for_ex = iter_op & ~done_q & ~div_ready;

  // done blocks re-issue until a new instruction enters EX
  always_comb begin
    done_d = done_q;
    if (in_load)        done_d = 1'b0;
    else if (div_ready) done_d = 1'b1;
  end

`ifndef EX_MUL_ITER_EN
  logic [63:0] mul_a, mul_b, product;

  // single-cycle product, sign handled by extension to 64 bits
  always_comb begin
    mul_a   = is_mult ? {{32{id_q.rdata1[31]}}, id_q.rdata1}
                      : {32'd0, id_q.rdata1};
    mul_b   = is_mult ? {{32{id_q.rdata2[31]}}, id_q.rdata2}
                      : {32'd0, id_q.rdata2};
    product = mul_a * mul_b;
  end
`endif

  // HI/LO writes only when EX->MEM advances
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (stall[STALL_EX_MEM] == NO_STOP) begin
      if (iter_op && (div_ready || done_q)) begin
        hi_d = div_result[63:32];
        lo_d = div_result[31:0];
      end
`ifndef EX_MUL_ITER_EN
      else if (is_mult || is_multu) begin
        hi_d = product[63:32];
        lo_d = product[31:0];
      end
`endif
      else if (is_mthi) hi_d = id_q.rdata1;
      else if (is_mtlo) lo_d = id_q.rdata1;
    end
  end

  // operand muxes
  always_comb begin
    imm_s = {{16{id_q.inst[15]}}, id_q.inst[15:0]};
    imm_z = {16'd0, id_q.inst[15:0]};
    unique case (1'b1)
      id_q.sel_alu_src1[0]: src1 = id_q.rdata1;
      id_q.sel_alu_src1[1]: src1 = id_q.pc;
      id_q.sel_alu_src1[2]: src1 = {27'd0, id_q.inst[10:6]};
      default:              src1 = '0;
    endcase
    unique case (1'b1)
      id_q.sel_alu_src2[0]: src2 = id_q.rdata2;
      id_q.sel_alu_src2[1]: src2 = imm_s;
      id_q.sel_alu_src2[2]: src2 = 32'd8;
      id_q.sel_alu_src2[3]: src2 = imm_z;
      default:              src2 = '0;
    endcase
  end

  // ALU, one-hot op select
  always_comb begin
    unique case (1'b1)
      id_q.alu_op[ALU_ADD]:  alu_res = src1 + src2;
      id_q.alu_op[ALU_SUB]:  alu_res = src1 - src2;
      id_q.alu_op[ALU_SLT]:
        alu_res = {31'd0, $signed(src1) < $signed(src2)};
      id_q.alu_op[ALU_SLTU]: alu_res = {31'd0, src1 < src2};
      id_q.alu_op[ALU_AND]:  alu_res = src1 & src2;
      id_q.alu_op[ALU_NOR]:  alu_res = ~(src1 | src2);
      id_q.alu_op[ALU_OR]:   alu_res = src1 | src2;
      id_q.alu_op[ALU_XOR]:  alu_res = src1 ^ src2;
      id_q.alu_op[ALU_SLL]:  alu_res = src2 << src1[4:0];
      id_q.alu_op[ALU_SRL]:  alu_res = src2 >> src1[4:0];
      id_q.alu_op[ALU_SRA]:
        alu_res = $signed(src2) >>> src1[4:0];
      id_q.alu_op[ALU_LUI]:  alu_res = {id_q.inst[15:0], 16'd0};
      default:               alu_res = '0;
    endcase
  end

  // result select and writeback fields
  always_comb begin
    ex_result = alu_res;
    rf_we     = id_q.rf_we;
    rf_waddr  = id_q.rf_waddr;
    if (is_mfhi) ex_result = hi_q;
    if (is_mflo) ex_result = lo_q;
    if (is_mfhi || is_mflo) begin
      rf_we    = 1'b1;
      rf_waddr = id_q.inst[15:11];
    end
  end

  // output bundles
  always_comb begin
    mem_out.pc           = id_q.pc;
    mem_out.data_ram_en  = id_q.data_ram_en;
    mem_out.data_ram_wen = id_q.data_ram_wen;
    mem_out.sel_rf_res   = id_q.sel_rf_res;
    mem_out.rf_we        = rf_we;
    mem_out.rf_waddr     = rf_waddr;
    mem_out.ex_result    = ex_result;
  end

  assign ex_to_mem_bus   = mem_out;
  assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
  assign data_sram_en    = id_q.data_ram_en;
  assign data_sram_wen   = id_q.data_ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = id_q.rdata2;

  assign unused_bits = ^{stall[5:4], stall[1:0], id_q.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Stall bus mimics a hazard unit: stallreq holds IF..EX.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [5:0]   stall_ext;
  logic [158:0] bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq;

  int checks = 0;
  int errors = 0;
  int cnt;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

`ifdef EX_MUL_ITER_EN
  localparam int MUL_STALL = 33;
`else
  localparam int MUL_STALL = 0;
`endif

  assign stall = stallreq ? 6'b001111 : stall_ext;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [158:0] mk(
    input logic [31:0] pc,
    input logic [31:0] inst,
    input logic [11:0] op,
    input logic [2:0]  s1,
    input logic [3:0]  s2,
    input logic        en,
    input logic [3:0]  wen,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] r1,
    input logic [31:0] r2);
    return {pc, inst, op, s1, s2, en, wen, we, wa, 1'b0, r1, r2};
  endfunction

  function automatic logic [158:0] rop(
    input logic [5:0]  fn,
    input logic [4:0]  rd,
    input logic [31:0] r1,
    input logic [31:0] r2);
    return mk(32'h0000_2000, {16'd0, rd, 5'd0, fn}, 12'd0,
              3'd0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, r1, r2);
  endfunction

  task automatic chk(input string tag,
                     input logic [75:0] obs,
                     input logic [75:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic count_stall;
    cnt = 0;
    while (stallreq === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    stall_ext = 6'd0;
    bus       = '0;
    #1;
    chk("rst_mem_bus", ex_to_mem_bus, 76'd0);
    chk("rst_rf_bus", ex_to_rf_bus, 76'd0);
    chk("rst_stallreq", stallreq, 76'd0);
    chk("rst_sram_en", data_sram_en, 76'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    bus = mk(32'h400, {6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h21},
             OP_ADD, 3'b001, 4'b0001, 1'b0, 4'd0, 1'b1, 5'd9,
             32'd5, 32'hFFFF_FFFF);
    step();
    chk("addu_rf_bus", ex_to_rf_bus, {38'd0, 1'b1, 5'd9, 32'd4});
    chk("addu_mem_bus", ex_to_mem_bus,
        {32'h400, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd4});

    bus = mk(32'h404, 32'd0, OP_SUB, 3'b001, 4'b0001, 1'b0, 4'd0,
             1'b1, 5'd3, 32'd3, 32'd5);
    step();
    chk("sub", data_sram_addr, 76'hFFFF_FFFE);

    bus = mk(32'h408, 32'd0, OP_SLT, 3'b001, 4'b0001, 1'b0, 4'd0,
             1'b1, 5'd3, 32'hFFFF_FFFD, 32'd2);
    step();
    chk("slt", data_sram_addr, 76'd1);

    bus = mk(32'h40C, 32'd0, OP_SLTU, 3'b001, 4'b0001, 1'b0, 4'd0,
             1'b1, 5'd3, 32'hFFFF_FFFD, 32'd2);
    step();
    chk("sltu", data_sram_addr, 76'd0);

    bus = mk(32'h410, {6'd0, 15'd0, 5'd4, 6'h03}, OP_SRA, 3'b100,
             4'b0001, 1'b0, 4'd0, 1'b1, 5'd3, 32'd0, 32'h8000_0000);
    step();
    chk("sra", data_sram_addr, 76'hF800_0000);

    bus = mk(32'h414, {6'd0, 15'd0, 5'd4, 6'h02}, OP_SRL, 3'b100,
             4'b0001, 1'b0, 4'd0, 1'b1, 5'd3, 32'd0, 32'h8000_0000);
    step();
    chk("srl", data_sram_addr, 76'h0800_0000);

    bus = mk(32'h418, {6'h0F, 5'd0, 5'd8, 16'h1234}, OP_LUI, 3'b000,
             4'b1000, 1'b0, 4'd0, 1'b1, 5'd8, 32'd0, 32'd0);
    step();
    chk("lui", data_sram_addr, 76'h1234_0000);

    bus = mk(32'h1000, 32'd0, OP_ADD, 3'b010, 4'b0100, 1'b0, 4'd0,
             1'b1, 5'd31, 32'd0, 32'd0);
    step();
    chk("pc_plus8", data_sram_addr, 76'h1008);

    bus = mk(32'h41C, 32'd0, OP_NOR, 3'b001, 4'b0001, 1'b0, 4'd0,
             1'b1, 5'd3, 32'h0F0F_0000, 32'h00FF_00FF);
    step();
    chk("nor", data_sram_addr, 76'hF000_FF00);

    bus = mk(32'h420, {6'h2B, 5'd4, 5'd5, 16'h0008}, OP_ADD, 3'b001,
             4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 32'h100, 32'hDEAD_BEEF);
    step();
    chk("sw_en", data_sram_en, 76'd1);
    chk("sw_wen", data_sram_wen, 76'hF);
    chk("sw_addr", data_sram_addr, 76'h108);
    chk("sw_wdata", data_sram_wdata, 76'hDEAD_BEEF);

    stall_ext = 6'b001100;
    bus = mk(32'h424, {6'h23, 5'd4, 5'd5, 16'hFFFC}, OP_ADD, 3'b001,
             4'b0010, 1'b1, 4'h0, 1'b1, 5'd5, 32'h100, 32'd0);
    step();
    chk("hold_addr", data_sram_addr, 76'h108);
    stall_ext = 6'd0;
    step();
    chk("lw_neg_imm", data_sram_addr, 76'hFC);

    stall_ext = 6'b000100;
    step();
    chk("bubble_mem_bus", ex_to_mem_bus, 76'd0);
    chk("bubble_sram_en", data_sram_en, 76'd0);
    stall_ext = 6'd0;

    bus = rop(6'h18, 5'd0, 32'hFFFF_FFFF, 32'd2);
    step();
    bus = rop(6'h10, 5'd3, 32'd0, 32'd0);
    count_stall();
    chk("mult_stall", cnt, MUL_STALL);
    step();
    chk("mult_hi", ex_to_rf_bus, {38'd0, 1'b1, 5'd3, 32'hFFFF_FFFF});
    bus = rop(6'h12, 5'd4, 32'd0, 32'd0);
    step();
    chk("mult_lo", ex_to_rf_bus, {38'd0, 1'b1, 5'd4, 32'hFFFF_FFFE});

    bus = rop(6'h1A, 5'd0, 32'd7, 32'hFFFF_FFFE);
    step();
    bus = rop(6'h12, 5'd6, 32'd0, 32'd0);
    count_stall();
    chk("div_stall", cnt, 76'd33);
    step();
    chk("div_lo", ex_to_rf_bus, {38'd0, 1'b1, 5'd6, 32'hFFFF_FFFD});
    bus = rop(6'h10, 5'd7, 32'd0, 32'd0);
    step();
    chk("div_hi", data_sram_addr, 76'd1);

    bus = rop(6'h1B, 5'd0, 32'd10, 32'd0);
    step();
    bus = rop(6'h12, 5'd6, 32'd0, 32'd0);
    count_stall();
    chk("divu0_stall", cnt, 76'd1);
    step();
    chk("divu0_lo", data_sram_addr, 76'hFFFF_FFFF);
    bus = rop(6'h10, 5'd7, 32'd0, 32'd0);
    step();
    chk("divu0_hi", data_sram_addr, 76'd10);

    bus = rop(6'h11, 5'd0, 32'h0000_A5A5, 32'd0);
    step();
    bus = rop(6'h10, 5'd7, 32'd0, 32'd0);
    step();
    chk("mthi", data_sram_addr, 76'hA5A5);

    bus = rop(6'h1A, 5'd0, 32'd100, 32'd7);
    step();
    chk("div2_start_stall", stallreq, 76'd1);
    repeat (11) @(posedge clk);
    #1;
    chk("div2_mid_stall", stallreq, 76'd1);
    rst = 1'b1;
    #1;
    chk("abort_stallreq", stallreq, 76'd0);
    chk("abort_mem_bus", ex_to_mem_bus, 76'd0);
    @(negedge clk);
    rst = 1'b0;
    bus = rop(6'h10, 5'd7, 32'd0, 32'd0);
    step();
    chk("abort_hi", data_sram_addr, 76'd0);
    chk("abort_no_stall", stallreq, 76'd0);
    bus = rop(6'h12, 5'd6, 32'd0, 32'd0);
    step();
    chk("abort_lo", data_sram_addr, 76'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
